// File: rtl/in_frame_checker_pkg.sv
// Shared constants for the inbound frame checker: header layout, CRC-16-CCITT
// settings, desc_err bit positions and FSM encodings.
package in_frame_checker_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned PORT_NUB_TOTAL = 16;

  localparam int unsigned CRC_WIDTH = 16;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;

  // Header: {.., length, crc[15:0], priority}; offsets scale with the priority width
  localparam int unsigned HDR_PRIO_LSB = 0;

  function automatic int unsigned hdr_crc_lsb(input int unsigned prio_w);
    return HDR_PRIO_LSB + prio_w;
  endfunction

  function automatic int unsigned hdr_len_lsb(input int unsigned prio_w);
    return HDR_PRIO_LSB + prio_w + CRC_WIDTH;
  endfunction

  localparam int unsigned ERR_WIDTH   = 3;
  localparam int unsigned ERR_CRC_BIT = 0;
  localparam int unsigned ERR_LEN_BIT = 1;
  localparam int unsigned ERR_TMO_BIT = 2;

  typedef logic [ERR_WIDTH-1:0] err_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

endpackage

// File: rtl/crc16_word_step.sv
// Combinational CRC-16-CCITT update over one full data word, MSB first,
// no reflection.
module crc16_word_step #(
  parameter int unsigned DATA_WIDTH = in_frame_checker_pkg::DATA_WIDTH
) (
  input  logic [in_frame_checker_pkg::CRC_WIDTH-1:0] crc_i,
  input  logic [DATA_WIDTH-1:0]                      data_i,
  output logic [in_frame_checker_pkg::CRC_WIDTH-1:0] crc_o
);
  import in_frame_checker_pkg::*;

  logic [CRC_WIDTH-1:0]  crc_v;
  logic [DATA_WIDTH-1:0] shift_v;
  logic                  fb_v;

  always_comb begin
    crc_v   = crc_i;
    shift_v = data_i;
    fb_v    = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fb_v    = crc_v[CRC_WIDTH-1] ^ shift_v[DATA_WIDTH-1];
      crc_v   = {crc_v[CRC_WIDTH-2:0], 1'b0} ^ (fb_v ? CRC_POLY : '0);
      shift_v = shift_v << 1;
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/in_frame_checker.sv
// Inbound frame checker: parses a header word, forwards payload with one
// cycle of latency, checks CRC/length/idle timeout and emits a descriptor.
module in_frame_checker #(
  parameter int unsigned DATA_WIDTH     = in_frame_checker_pkg::DATA_WIDTH,
  parameter int unsigned WIDTH_SEL      = $clog2(in_frame_checker_pkg::PORT_NUB_TOTAL),
  parameter int unsigned WIDTH_LENGTH   = 9,
  parameter int unsigned WIDTH_PRIORITY = 3,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [WIDTH_SEL-1:0]      rx,
  input  logic [WIDTH_SEL-1:0]      tx,
  output logic                      pld_vld,
  output logic [DATA_WIDTH-1:0]     pld_data,
  output logic                      pld_last,
  output logic                      desc_vld,
  input  logic                      desc_ready,
  output logic [WIDTH_SEL-1:0]      desc_dest,
  output logic [WIDTH_SEL-1:0]      desc_src,
  output logic [WIDTH_PRIORITY-1:0] desc_priority,
  output logic [WIDTH_LENGTH-1:0]   desc_length,
  output logic [2:0]                desc_err,
  output logic [15:0]               drop_cnt
);
  import in_frame_checker_pkg::*;

  localparam int unsigned GAP_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned LEN_LSB = hdr_len_lsb(WIDTH_PRIORITY);
  localparam int unsigned CRC_LSB = hdr_crc_lsb(WIDTH_PRIORITY);

  logic [1:0]                state_q, state_d;
  logic [WIDTH_SEL-1:0]      dest_q, dest_d, src_q, src_d;
  logic [WIDTH_PRIORITY-1:0] prio_q, prio_d;
  logic [WIDTH_LENGTH-1:0]   len_q, len_d;
  logic [CRC_WIDTH-1:0]      crc_hdr_q, crc_hdr_d;
  logic [CRC_WIDTH-1:0]      crc_q, crc_d;
  logic [WIDTH_LENGTH-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic                      tmo_q, tmo_d;

  logic                      pld_vld_q, pld_vld_d;
  logic [DATA_WIDTH-1:0]     pld_data_q, pld_data_d;
  logic                      pld_last_q, pld_last_d;

  logic                      desc_vld_q, desc_vld_d;
  logic [WIDTH_SEL-1:0]      desc_dest_q, desc_dest_d, desc_src_q, desc_src_d;
  logic [WIDTH_PRIORITY-1:0] desc_prio_q, desc_prio_d;
  logic [WIDTH_LENGTH-1:0]   desc_len_q, desc_len_d;
  err_t                      desc_err_q, desc_err_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;

  logic [CRC_WIDTH-1:0]      crc_next;
  logic [WIDTH_LENGTH-1:0]   hdr_len, cnt_inc;
  logic [GAP_W-1:0]          gap_inc;
  logic                      hdr_accept;
  err_t                      chk_err;

  crc16_word_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_crc_step (
    .crc_i (crc_q),
    .data_i(data),
    .crc_o (crc_next)
  );

  assign hdr_len = data[LEN_LSB +: WIDTH_LENGTH];
  assign cnt_inc = cnt_q + WIDTH_LENGTH'(1);
  assign gap_inc = gap_q + GAP_W'(1);

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    src_d      = src_q;
    prio_d     = prio_q;
    len_d      = len_q;
    crc_hdr_d  = crc_hdr_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    pld_vld_d  = 1'b0;
    pld_data_d = pld_data_q;
    pld_last_d = 1'b0;
    hdr_accept = 1'b0;

    case (state_q)
      ST_IDLE: hdr_accept = vld;
      ST_PAYLOAD: begin
        if (vld) begin
          pld_vld_d  = 1'b1;
          pld_data_d = data;
          crc_d      = crc_next;
          cnt_d      = cnt_inc;
          gap_d      = '0;
          if (cnt_inc == len_q) begin
            pld_last_d = 1'b1;
            state_d    = ST_CHECK;
          end
        end else begin
          gap_d = gap_inc;
          if (gap_inc == GAP_W'(TIMEOUT)) begin
            tmo_d   = 1'b1;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        state_d    = ST_IDLE;
        hdr_accept = vld;
      end
      default: state_d = ST_IDLE;
    endcase

    // A header in the CHECK cycle overwrites frame state only after CHECK
    // has used it, since the descriptor is built from the _q registers.
    if (hdr_accept) begin
      dest_d    = rx;
      src_d     = tx;
      prio_d    = data[HDR_PRIO_LSB +: WIDTH_PRIORITY];
      len_d     = hdr_len;
      crc_hdr_d = data[CRC_LSB +: CRC_WIDTH];
      crc_d     = CRC_INIT;
      cnt_d     = '0;
      gap_d     = '0;
      tmo_d     = 1'b0;
      state_d   = (hdr_len == '0) ? ST_CHECK : ST_PAYLOAD;
    end
  end

  always_comb begin
    chk_err              = '0;
    chk_err[ERR_TMO_BIT] = tmo_q;
    chk_err[ERR_LEN_BIT] = (len_q == '0);
    chk_err[ERR_CRC_BIT] = !tmo_q && (crc_q != crc_hdr_q);

    desc_vld_d  = desc_vld_q;
    desc_dest_d = desc_dest_q;
    desc_src_d  = desc_src_q;
    desc_prio_d = desc_prio_q;
    desc_len_d  = desc_len_q;
    desc_err_d  = desc_err_q;
    drop_cnt_d  = drop_cnt_q;

    if (state_q == ST_CHECK) begin
      if (desc_vld_q && !desc_ready) begin
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        desc_vld_d  = 1'b1;
        desc_dest_d = dest_q;
        desc_src_d  = src_q;
        desc_prio_d = prio_q;
        desc_len_d  = len_q;
        desc_err_d  = chk_err;
      end
    end else if (desc_vld_q && desc_ready) begin
      desc_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      src_q       <= '0;
      prio_q      <= '0;
      len_q       <= '0;
      crc_hdr_q   <= '0;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= 1'b0;
      pld_vld_q   <= 1'b0;
      pld_data_q  <= '0;
      pld_last_q  <= 1'b0;
      desc_vld_q  <= 1'b0;
      desc_dest_q <= '0;
      desc_src_q  <= '0;
      desc_prio_q <= '0;
      desc_len_q  <= '0;
      desc_err_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      prio_q      <= prio_d;
      len_q       <= len_d;
      crc_hdr_q   <= crc_hdr_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      pld_vld_q   <= pld_vld_d;
      pld_data_q  <= pld_data_d;
      pld_last_q  <= pld_last_d;
      desc_vld_q  <= desc_vld_d;
      desc_dest_q <= desc_dest_d;
      desc_src_q  <= desc_src_d;
      desc_prio_q <= desc_prio_d;
      desc_len_q  <= desc_len_d;
      desc_err_q  <= desc_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign pld_vld       = pld_vld_q;
  assign pld_data      = pld_data_q;
  assign pld_last      = pld_last_q;
  assign desc_vld      = desc_vld_q;
  assign desc_dest     = desc_dest_q;
  assign desc_src      = desc_src_q;
  assign desc_priority = desc_prio_q;
  assign desc_length   = desc_len_q;
  assign desc_err      = desc_err_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_in_frame_checker.sv
// Scenario bench for in_frame_checker: payload words are scoreboarded through
// a queue, descriptors are checked at their required cycle.
module tb_in_frame_checker;
  localparam int DW  = 32;
  localparam int WS  = 4;
  localparam int WL  = 9;
  localparam int WP  = 3;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst, vld, desc_ready;
  logic [DW-1:0] data;
  logic [WS-1:0] rx, tx;
  logic          pld_vld, pld_last, desc_vld;
  logic [DW-1:0] pld_data;
  logic [WS-1:0] desc_dest, desc_src;
  logic [WP-1:0] desc_priority;
  logic [WL-1:0] desc_length;
  logic [2:0]    desc_err;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed { logic [DW-1:0] d; logic last; } pld_t;
  pld_t pq[$];

  in_frame_checker #(
    .DATA_WIDTH(DW), .WIDTH_SEL(WS), .WIDTH_LENGTH(WL),
    .WIDTH_PRIORITY(WP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .vld(vld), .data(data), .rx(rx), .tx(tx),
    .pld_vld(pld_vld), .pld_data(pld_data), .pld_last(pld_last),
    .desc_vld(desc_vld), .desc_ready(desc_ready), .desc_dest(desc_dest),
    .desc_src(desc_src), .desc_priority(desc_priority), .desc_length(desc_length),
    .desc_err(desc_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Payload scoreboard: every forwarded word must match the next expected one.
  always @(negedge clk) begin
    if (pld_vld) begin
      n_cmp++;
      if (pq.size() == 0) begin
        n_err++;
        $display("FAIL payload_unexpected: got data=%h last=%b, expected none", pld_data, pld_last);
      end else begin
        pld_t e;
        e = pq.pop_front();
        if ({pld_data, pld_last} !== {e.d, e.last}) begin
          n_err++;
          $display("FAIL payload: got data=%h last=%b, expected data=%h last=%b",
                   pld_data, pld_last, e.d, e.last);
        end
      end
    end
  end

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [DW-1:0] d);
    logic fb;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] make_hdr(input logic [WL-1:0] len, input logic [15:0] crc,
                                             input logic [WP-1:0] prio);
    logic [DW-1:0] h;
    h        = '0;
    h[27:19] = len;
    h[18:3]  = crc;
    h[2:0]   = prio;
    return h;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d);
    vld  = v;
    data = d;
    @(posedge clk);
    #1;
    vld  = 1'b0;
    data = '0;
  endtask

  // Header plus nsend payload words; header CRC always covers the intact payload.
  task automatic send_frame(input logic [WL-1:0] len, input int nsend, input int flip,
                            input logic [WS-1:0] r, input logic [WS-1:0] t,
                            input logic [WP-1:0] prio);
    logic [DW-1:0] w [8];
    logic [DW-1:0] word;
    logic [15:0]   crc;
    crc = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      if (i < int'(len)) crc = crc_ref(crc, w[i]);
    end
    rx = r;
    tx = t;
    drive(1'b1, make_hdr(len, crc, prio));
    for (int i = 0; i < nsend; i++) begin
      word = w[i] ^ ((i == flip) ? 32'h0000_0004 : 32'h0);
      pq.push_back('{d: word, last: (i == int'(len) - 1)});
      drive(1'b1, word);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; vld = 1'b0; data = '0; rx = '0; tx = '0; desc_ready = 1'b1;
    repeat (3) drive(1'b0, '0);
    rst = 1'b0;
    n_cmp++;
    if ({pld_vld, pld_last, desc_vld, desc_dest, desc_src, desc_priority, desc_length,
         desc_err, drop_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got vld=%b last=%b dvld=%b dest=%h src=%h len=%h err=%b drop=%h, expected all 0",
               pld_vld, pld_last, desc_vld, desc_dest, desc_src, desc_length, desc_err, drop_cnt);
    end
  endtask

  task automatic test_good_frame;
    send_frame(9'd4, 4, -1, 4'd3, 4'd7, 3'd5);
    n_cmp++;
    if (desc_vld !== 1'b0) begin
      n_err++; $display("FAIL good_desc_early: got desc_vld=%b, expected 0", desc_vld);
    end
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_dest, desc_src, desc_priority, desc_length, desc_err}
        !== {1'b1, 4'd3, 4'd7, 3'd5, 9'd4, 3'b000}) begin
      n_err++;
      $display("FAIL good_desc: got vld=%b dest=%0d src=%0d prio=%0d len=%0d err=%b, expected 1 3 7 5 4 000",
               desc_vld, desc_dest, desc_src, desc_priority, desc_length, desc_err);
    end
    drive(1'b0, '0);
    n_cmp++;
    if (desc_vld !== 1'b0) begin
      n_err++; $display("FAIL good_desc_accept: got desc_vld=%b, expected 0", desc_vld);
    end
  endtask

  task automatic test_crc_error;
    send_frame(9'd4, 4, 1, 4'd3, 4'd7, 3'd1);
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_length, desc_err} !== {1'b1, 9'd4, 3'b001}) begin
      n_err++;
      $display("FAIL crc_desc: got vld=%b len=%0d err=%b, expected 1 4 001", desc_vld, desc_length, desc_err);
    end
    drive(1'b0, '0);
  endtask

  task automatic test_timeout;
    send_frame(9'd8, 3, -1, 4'd9, 4'd2, 3'd6);
    repeat (TMO) drive(1'b0, '0);
    n_cmp++;
    if (desc_vld !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: got desc_vld=%b, expected 0", desc_vld);
    end
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_dest, desc_src, desc_err} !== {1'b1, 4'd9, 4'd2, 3'b100}) begin
      n_err++;
      $display("FAIL timeout_desc: got vld=%b dest=%0d src=%0d err=%b, expected 1 9 2 100",
               desc_vld, desc_dest, desc_src, desc_err);
    end
    drive(1'b0, '0);
    send_frame(9'd2, 2, -1, 4'd1, 4'd2, 3'd0);
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_dest, desc_length, desc_err} !== {1'b1, 4'd1, 9'd2, 3'b000}) begin
      n_err++;
      $display("FAIL timeout_recover: got vld=%b dest=%0d len=%0d err=%b, expected 1 1 2 000",
               desc_vld, desc_dest, desc_length, desc_err);
    end
    drive(1'b0, '0);
  endtask

  task automatic test_len_zero;
    send_frame(9'd0, 0, -1, 4'd5, 4'd6, 3'd2);
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_dest, desc_length, desc_err} !== {1'b1, 4'd5, 9'd0, 3'b010}) begin
      n_err++;
      $display("FAIL len_zero_desc: got vld=%b dest=%0d len=%0d err=%b, expected 1 5 0 010",
               desc_vld, desc_dest, desc_length, desc_err);
    end
    repeat (2) drive(1'b0, '0);
  endtask

  task automatic test_back_to_back;
    desc_ready = 1'b0;
    send_frame(9'd2, 2, -1, 4'd4, 4'd5, 3'd1);
    send_frame(9'd3, 3, -1, 4'd6, 4'd8, 3'd2);
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_dest, desc_src, desc_length, drop_cnt} !== {1'b1, 4'd4, 4'd5, 9'd2, 16'd1}) begin
      n_err++;
      $display("FAIL b2b_hold: got vld=%b dest=%0d src=%0d len=%0d drop=%0d, expected 1 4 5 2 1",
               desc_vld, desc_dest, desc_src, desc_length, drop_cnt);
    end
    desc_ready = 1'b1;
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, drop_cnt} !== {1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL b2b_accept: got vld=%b drop=%0d, expected 0 1", desc_vld, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    send_frame(9'd4, 2, -1, 4'd2, 4'd3, 3'd4);
    rst = 1'b1;
    drive(1'b0, '0);
    rst = 1'b0;
    repeat (3) drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, drop_cnt, pld_vld} !== {1'b0, 16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got desc_vld=%b drop=%0d pld_vld=%b, expected 0 0 0",
               desc_vld, drop_cnt, pld_vld);
    end
    send_frame(9'd4, 4, -1, 4'd11, 4'd12, 3'd3);
    drive(1'b0, '0);
    n_cmp++;
    if ({desc_vld, desc_dest, desc_src, desc_length, desc_err, drop_cnt}
        !== {1'b1, 4'd11, 4'd12, 9'd4, 3'b000, 16'd0}) begin
      n_err++;
      $display("FAIL reset_next_frame: got vld=%b dest=%0d src=%0d len=%0d err=%b drop=%0d, expected 1 11 12 4 000 0",
               desc_vld, desc_dest, desc_src, desc_length, desc_err, drop_cnt);
    end
    repeat (2) drive(1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_timeout();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_frame();
    n_cmp++;
    if (pq.size() != 0) begin
      n_err++;
      $display("FAIL payload_missing: got %0d words outstanding, expected 0", pq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
